// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared definitions for the bittyCore memory-stage LSU.
//               Provides the ALU op codes, the bus widths, the reset level,
//               the LSU state encoding and a memory-op decoder.
// Revision    : 1.0  initial release
// ============================================================================
package mem_lsu_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int REG_ADDR_W = 5;

  localparam logic RST_ENABLE = 1'b1;

  // Memory op codes (same encoding as the execute stage)
  localparam logic [ALU_OP_W-1:0] EXE_LB  = 8'b1110_0000;
  localparam logic [ALU_OP_W-1:0] EXE_LH  = 8'b1110_0001;
  localparam logic [ALU_OP_W-1:0] EXE_LW  = 8'b1110_0011;
  localparam logic [ALU_OP_W-1:0] EXE_LBU = 8'b1110_0100;
  localparam logic [ALU_OP_W-1:0] EXE_LHU = 8'b1110_0101;
  localparam logic [ALU_OP_W-1:0] EXE_SB  = 8'b1110_1000;
  localparam logic [ALU_OP_W-1:0] EXE_SH  = 8'b1110_1001;
  localparam logic [ALU_OP_W-1:0] EXE_SW  = 8'b1110_1011;
  localparam logic [ALU_OP_W-1:0] EXE_ADD = 8'b0010_0000;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      is_store;
    logic      is_signed;
    mem_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [ALU_OP_W-1:0] op);
    mem_op_t d;
    d.is_mem    = 1'b1;
    d.is_load   = 1'b0;
    d.is_store  = 1'b0;
    d.is_signed = 1'b0;
    d.size      = SZ_WORD;
    case (op)
      EXE_LB:  begin d.is_load  = 1'b1; d.is_signed = 1'b1; d.size = SZ_BYTE; end
      EXE_LBU: begin d.is_load  = 1'b1;                     d.size = SZ_BYTE; end
      EXE_LH:  begin d.is_load  = 1'b1; d.is_signed = 1'b1; d.size = SZ_HALF; end
      EXE_LHU: begin d.is_load  = 1'b1;                     d.size = SZ_HALF; end
      EXE_LW:  begin d.is_load  = 1'b1;                     d.size = SZ_WORD; end
      EXE_SB:  begin d.is_store = 1'b1;                     d.size = SZ_BYTE; end
      EXE_SH:  begin d.is_store = 1'b1;                     d.size = SZ_HALF; end
      EXE_SW:  begin d.is_store = 1'b1;                     d.size = SZ_WORD; end
      default: d.is_mem = 1'b0;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_align
// Description : Combinational lane logic for the LSU.
//               Store side: byte enables and lane-replicated write data.
//               Load side : byte/halfword extraction with sign/zero extension.
//               Also flags accesses that are not naturally aligned.
// Ports       : is_mem_i, is_signed_i, size_i - decoded op
//               addr_lo_i  - byte offset within the word
//               reg2_i     - store source data
//               rdata_i    - read word from the bus
//               misalign_o, be_o, st_data_o, ld_data_o - results
// Revision    : 1.0  initial release
// ============================================================================
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic        is_mem_i,
  input  logic        is_signed_i,
  input  mem_size_e   size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic       bad_align;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  always_comb begin
    bad_align = 1'b0;
    be_o      = 4'b0000;
    st_data_o = 32'd0;
    ld_data_o = 32'd0;
    lane_b    = 8'd0;
    lane_h    = 16'd0;
    case (size_i)
      SZ_BYTE: begin
        be_o      = 4'b0001 << addr_lo_i;
        st_data_o = {4{reg2_i[7:0]}};
        case (addr_lo_i)
          2'd0:    lane_b = rdata_i[7:0];
          2'd1:    lane_b = rdata_i[15:8];
          2'd2:    lane_b = rdata_i[23:16];
          default: lane_b = rdata_i[31:24];
        endcase
        ld_data_o = {{24{is_signed_i & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        bad_align = addr_lo_i[0];
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_data_o = {2{reg2_i[15:0]}};
        lane_h    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        ld_data_o = {{16{is_signed_i & lane_h[15]}}, lane_h};
      end
      default: begin
        bad_align = |addr_lo_i;
        be_o      = 4'b1111;
        st_data_o = reg2_i;
        ld_data_o = rdata_i;
      end
    endcase
    // Only memory ops can be misaligned; other ops carry arbitrary ALU results
    misalign_o = is_mem_i & bad_align;
  end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Memory-stage load/store unit. Issues one req/ack data-bus
//               transaction per aligned memory op, stalls the pipeline while
//               it is outstanding and returns formatted load data to mem_wb.
// Ports       : clk, rst                     - clock, sync active-high reset
//               mem_aluop_i/addr_i/reg2_i    - op, address, store data
//               wd_i/wreg_i/wdata_i          - write-back from ex
//               wd_o/wreg_o/wdata_o          - write-back to mem_wb
//               dbus_*                       - data bus (registered request)
//               stall_req_o                  - pipeline hold to ctrl
//               misalign_o, bus_err_o        - one-cycle event pulses
// Parameters  : ACK_TIMEOUT - WAIT cycles before abort, 0 disables
// Revision    : 1.0  initial release
// ============================================================================
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALU_OP_W-1:0]   mem_aluop_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [31:0]           dbus_addr_o,
  output logic [3:0]            dbus_be_o,
  output logic [31:0]           dbus_wdata_o,
  input  logic [31:0]           dbus_rdata_i,
  input  logic                  dbus_ack_i,
  output logic                  stall_req_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  // Counter only has to reach ACK_TIMEOUT-1
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  lsu_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      bwdata_q, bwdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  mem_op_t     dec;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_st_data;
  logic [31:0] w_ld_data;
  logic        w_timeout;
  logic        w_abort;

  assign dec = decode_op(mem_aluop_i);

  mem_lsu_align u_align (
    .is_mem_i    (dec.is_mem),
    .is_signed_i (dec.is_signed),
    .size_i      (dec.size),
    .addr_lo_i   (mem_addr_i[1:0]),
    .reg2_i      (mem_reg2_i),
    .rdata_i     (dbus_rdata_i),
    .misalign_o  (w_misalign),
    .be_o        (w_be),
    .st_data_o   (w_st_data),
    .ld_data_o   (w_ld_data)
  );

  assign w_timeout = (ACK_TIMEOUT != 0) && (32'(cnt_q) == 32'(ACK_TIMEOUT - 1));
  // Ack wins over a timeout landing in the same cycle
  assign w_abort   = (state_q == LSU_WAIT) && !dbus_ack_i && w_timeout;

  // Next-state and bus request registers
  always_comb begin
    state_d  = state_q;
    req_d    = 1'b0;
    we_d     = 1'b0;
    be_d     = 4'b0000;
    addr_d   = 32'd0;
    bwdata_d = 32'd0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      LSU_IDLE: begin
        if (dec.is_mem && !w_misalign) begin
          state_d  = LSU_WAIT;
          req_d    = 1'b1;
          we_d     = dec.is_store;
          be_d     = w_be;
          addr_d   = {mem_addr_i[31:2], 2'b00};
          bwdata_d = dec.is_store ? w_st_data : 32'd0;
          cnt_d    = '0;
        end
      end
      LSU_WAIT: begin
        if (dbus_ack_i) begin
          state_d = LSU_DONE;
          rdata_d = w_ld_data;
        end else if (w_timeout) begin
          state_d = LSU_IDLE;
        end else begin
          // Hold the request stable until ack or abort
          req_d    = req_q;
          we_d     = we_q;
          be_d     = be_q;
          addr_d   = addr_q;
          bwdata_d = bwdata_q;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= LSU_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= 32'd0;
      bwdata_q <= 32'd0;
      rdata_q  <= 32'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      bwdata_q <= bwdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_be_o    = be_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = bwdata_q;

  // Write-back path and pipeline control
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    if (rst != RST_ENABLE) begin
      wd_o      = wd_i;
      wreg_o    = wreg_i;
      wdata_o   = wdata_i;
      bus_err_o = w_abort;
      if (dec.is_mem) begin
        // Memory ops only write back from DONE, and only for loads
        wreg_o = 1'b0;
        if (w_misalign) begin
          misalign_o = 1'b1;
        end else begin
          // Releasing on abort lets the pipeline move past the failed op
          stall_req_o = (state_q != LSU_DONE) && !w_abort;
          if ((state_q == LSU_DONE) && dec.is_load) begin
            wreg_o  = wreg_i;
            wdata_o = rdata_q;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit for the bittyCore pipeline. It sits between the ex_mem pipeline register and mem_wb. It receives the ALU op, effective address and store data produced by the execute stage, and performs the corresponding data-bus transaction with a req/ack handshake. While a transaction is outstanding it stalls the pipeline through ctrl. It then returns the aligned, sign- or zero-extended load data on the register write-back path.

## Interface
Parameters:
- ACK_TIMEOUT, 255 — cycles to wait for dbus_ack_i before aborting; 0 disables the timeout.

Ports:
- clk  in  1  — single clock; all state updates on its rising edge.
- rst  in  1  — synchronous, active-high reset (`RstEnable`).
- mem_aluop_i  in  `AluOpBus` — op from ex_mem (`EXE_LB/LH/LW/LBU/LHU/SB/SH/SW`, or other).
- mem_addr_i  in  32 — effective byte address.
- mem_reg2_i  in  32 — store source data.
- wd_i  in  `RegAddrBus` — destination register.
- wreg_i  in  1 — write enable from ex.
- wdata_i  in  32 — non-memory result.
- wd_o  out  `RegAddrBus` — to mem_wb.
- wreg_o  out  1 — to mem_wb.
- wdata_o  out  32 — to mem_wb.
- dbus_req_o  out  1 — transaction request (registered).
- dbus_we_o  out  1 — 1 = store.
- dbus_addr_o  out  32 — word-aligned address, {mem_addr_i[31:2],2'b00}.
- dbus_be_o  out  4 — byte enables.
- dbus_wdata_o  out  32 — lane-replicated store data.
- dbus_rdata_i  in  32 — read word, valid with ack.
- dbus_ack_i  in  1 — completion; sampled only while dbus_req_o=1.
- stall_req_o  out  1 — to ctrl; holds ex_mem and earlier stages.
- misalign_o  out  1 — one-cycle pulse on a misaligned access.
- bus_err_o  out  1 — one-cycle pulse on timeout.

## Operation
- **FSM states:**
  - IDLE → WAIT when a memory op is present and aligned; dbus_req_o is set at the next edge.
  - WAIT → DONE on ack, capturing the formatted load data into rdata_q.
  - WAIT → IDLE on timeout, pulsing bus_err_o.
  - DONE → IDLE unconditionally.
- **Non-memory op:** wd_o/wreg_o/wdata_o = wd_i/wreg_i/wdata_i combinationally; no stall; bus idle.
- **stall_req_o:** 1 when an aligned memory op is present and state ≠ DONE.
- **Write-back in DONE:** wdata_o = rdata_q for loads; wreg_o = wreg_i for loads and 0 for stores.
- **Misaligned access:** LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - No bus access, no stall.
  - misalign_o=1 and wreg_o=0 for the cycle the op is presented.
- **Store byte enables and data:**
  - SB: be = 4'b0001<<addr[1:0], data {4{reg2[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, data {2{reg2[15:0]}}.
  - SW: be = 4'b1111, data reg2.
- **Loads:** dbus_be_o uses the same lane pattern as the equivalent store.
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **Held request:** dbus_addr_o/be/we/wdata are held stable from req rise until ack or abort.
- **Reset (rst=1):** outputs as follows, and the FSM enters IDLE.
  - dbus_req_o=0, dbus_we_o=0, dbus_be_o=0, dbus_addr_o=0, dbus_wdata_o=0.
  - stall_req_o=0, misalign_o=0, bus_err_o=0.
  - wreg_o=0, wdata_o=0, wd_o=0.
  - rdata_q=0, timeout counter=0.
- **Reset mid-transaction:** the request is dropped and the data discarded; an ack arriving after reset is ignored.
- **Stray ack:** an ack in IDLE or DONE is ignored.
- **Timeout:** the counter clears on entry to WAIT; an abort causes no register write.

## Timing
- **Zero-wait bus:** op presented at cycle 0, req high in cycle 1, ack in cycle 1, result in DONE at cycle 2. Pipeline stalls in cycles 0 and 1 and advances at the end of cycle 2.
- **Wait states:** each extra wait state adds one stall cycle.
- **Back-to-back memory ops:** minimum 3 cycles each; the next op is seen in IDLE one cycle after DONE.
- **Timeout abort:** at ACK_TIMEOUT cycles in WAIT without ack, req drops at the next edge.

## Structure
- **Shared constants in `bitty_defs.v`:**
  - op codes `EXE_LB`…`EXE_SW`.
  - `RstEnable`.
  - FSM state encodings LSU_IDLE/LSU_WAIT/LSU_DONE.
- **Sub-module lsu_align (combinational):** produces store byte enables and lane data, load extraction/extension, and the misalign check. It is instantiated once inside mem_lsu.

## Test plan
- **SB:** addr=0x1003, reg2=0xAABBCCDD, ack in 1st req cycle → be=1000, wdata=0xDDDDDDDD, addr_o=0x1000; 2 stall cycles; wreg_o=0.
- **LB then LBU:** addr=0x2001, rdata=0x00008000 → LB wdata_o=0xFFFFFF80, LBU wdata_o=0x00000080, each 3 cycles.
- **LH with wait states:** addr=0x2002, rdata=0x80010000, ack after 3 wait cycles → wdata_o=0xFFFF8001; stall held 5 cycles; bus signals stable throughout.
- **LW misaligned:** addr=0x3001 → misalign_o pulse; no req; no stall; wreg_o=0.
- **Timeout:** ACK_TIMEOUT=4, no ack → bus_err_o at WAIT cycle 4; req drops; stall releases; no write.
- **Reset during WAIT, then late ack:** → req=0 next edge; FSM IDLE; late ack ignored; subsequent ADD passes wdata_i through unstalled.
